// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM destination tracking, load-use stall, branch flush, memory freeze.
// Optional statistics counters are enabled by defining HAZ_STATS_EN.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_no_rs,
  input  logic             id_no_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic [REG_W-1:0] dst1cc,
  output logic [REG_W-1:0] dst2cc,
  output logic             fwd_no_rs,
  output logic             fwd_no_rt,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ldstall,
  output logic [CNT_W-1:0] stat_freeze,
  output logic [CNT_W-1:0] stat_flush
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FREEZE  = 2'd2
  } hazState_t;

  hazState_t        stateQ, stateD;
  logic [REG_W-1:0] exDst, memDst;
  logic             exWr, exLd, memWr;
  logic             ldHaz;

  assign dst1cc = exWr  ? exDst  : '0;
  assign dst2cc = memWr ? memDst : '0;
  assign state  = stateQ;

  always_comb begin
    fwd_no_rs   = id_no_rs | (id_rs == '0);
    fwd_no_rt   = id_no_rt | (id_rt == '0);
    ldHaz       = id_valid & exLd & exWr &
                  ((!fwd_no_rs && (id_rs == exDst)) || (!fwd_no_rt && (id_rt == exDst)));
    stateD      = RUN;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (mem_busy) begin
      stateD    = FREEZE;
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
    end else if (ldHaz) begin
      // branch operands come from the stalled load, so the branch waits too
      stateD      = LDSTALL;
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush = id_valid & br_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= RUN;
      exDst  <= '0;
      exWr   <= 1'b0;
      exLd   <= 1'b0;
      memDst <= '0;
      memWr  <= 1'b0;
    end else begin
      stateQ <= stateD;
      case (stateD)
        FREEZE: ;
        LDSTALL: begin
          memDst <= exDst;
          memWr  <= exWr;
          exDst  <= '0;
          exWr   <= 1'b0;
          exLd   <= 1'b0;
        end
        default: begin
          memDst <= exDst;
          memWr  <= exWr;
          exDst  <= id_valid ? id_dst : '0;
          exWr   <= id_valid & id_wr & (id_dst != '0);
          exLd   <= id_valid & id_load;
        end
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ldstall <= '0;
      stat_freeze  <= '0;
      stat_flush   <= '0;
    end else begin
      if (stateD == LDSTALL && stat_ldstall != '1) stat_ldstall <= stat_ldstall + 1'b1;
      if (stateD == FREEZE  && stat_freeze  != '1) stat_freeze  <= stat_freeze + 1'b1;
      if (ifid_flush        && stat_flush   != '1) stat_flush   <= stat_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding context, branch flush, freeze and reset.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_no_rs, id_no_rt, id_wr, id_load, br_taken, mem_busy;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [4:0] dst1cc, dst2cc;
  logic       fwd_no_rs, fwd_no_rt, pc_hold, ifid_hold, ifid_flush, idex_bubble;
  logic [1:0] state;
`ifdef HAZ_STATS_EN
  logic [15:0] stat_ldstall, stat_freeze, stat_flush;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_no_rs(id_no_rs), .id_no_rt(id_no_rt), .id_dst(id_dst), .id_wr(id_wr),
    .id_load(id_load), .br_taken(br_taken), .mem_busy(mem_busy),
    .dst1cc(dst1cc), .dst2cc(dst2cc), .fwd_no_rs(fwd_no_rs), .fwd_no_rt(fwd_no_rt),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .state(state)
`ifdef HAZ_STATS_EN
    , .stat_ldstall(stat_ldstall), .stat_freeze(stat_freeze), .stat_flush(stat_flush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic nors, input logic nort, input logic [4:0] dst,
                       input logic wr, input logic ld, input logic br, input logic busy);
    id_valid = v;   id_rs = rs;     id_rt = rt;  id_no_rs = nors; id_no_rt = nort;
    id_dst = dst;   id_wr = wr;     id_load = ld; br_taken = br;  mem_busy = busy;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_dst1", dst1cc, 0);
    chk("rst_dst2", dst2cc, 0);
    chk("rst_state", state, 0);
    reset = 1'b0;

    // load-use on rs: lw $5 then add rs=$5 rt=$6
    drive(1, 1, 2, 0, 0, 5, 1, 1, 0, 0);
    chk("ld_noholdyet", pc_hold, 0);
    tick();
    drive(1, 5, 6, 0, 0, 8, 1, 0, 0, 0);
    chk("lu_pchold", pc_hold, 1);
    chk("lu_ifidhold", ifid_hold, 1);
    chk("lu_bubble", idex_bubble, 1);
    chk("lu_dst1", dst1cc, 5);
    tick();
    chk("lu_state", state, 1);
    chk("lu_after_dst1", dst1cc, 0);
    chk("lu_after_dst2", dst2cc, 5);
    chk("lu_after_nohold", pc_hold, 0);
    tick();
    chk("lu_run_state", state, 0);
    chk("lu_add_dst1", dst1cc, 8);

    // non-load producer: add $7 then sub rs=$7
    drive(1, 1, 2, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 7, 3, 0, 0, 9, 1, 0, 0, 0);
    chk("alu_nostall", pc_hold, 0);
    chk("alu_dst1", dst1cc, 7);
    tick();
    chk("alu_dst2", dst2cc, 7);
    chk("alu_dst1b", dst1cc, 9);

    // $0 destination and no-source cases
    drive(1, 1, 2, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 11, 1, 1, 0, 0);
    chk("z_nostall", pc_hold, 0);
    chk("z_fwdnors", fwd_no_rs, 1);
    chk("z_dst1", dst1cc, 0);
    tick();
    drive(1, 3, 11, 0, 1, 12, 1, 0, 0, 0);
    chk("nort_nostall", pc_hold, 0);
    chk("nort_fwd", fwd_no_rt, 1);
    chk("nors_fwd_clear", fwd_no_rs, 0);
    drive(1, 3, 11, 0, 0, 12, 1, 0, 0, 0);
    chk("rt_match_stall", pc_hold, 1);
    drive(1, 3, 11, 0, 1, 12, 1, 0, 0, 0);
    tick();

    // branch flush in RUN, then branch during a load-use stall
    drive(1, 1, 2, 0, 0, 0, 0, 0, 1, 0);
    chk("br_flush", ifid_flush, 1);
    chk("br_nohold", pc_hold, 0);
    tick();
    drive(1, 1, 2, 0, 0, 13, 1, 1, 0, 0);
    chk("br_flush_once", ifid_flush, 0);
    tick();
    drive(1, 13, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("brst_noflush", ifid_flush, 0);
    chk("brst_hold", pc_hold, 1);
    tick();
    chk("brst_state", state, 1);
    drive(1, 1, 2, 0, 0, 9, 1, 0, 0, 0);
    tick();
    drive(1, 1, 2, 0, 0, 4, 1, 0, 0, 0);
    tick();
    chk("pre_frz_dst1", dst1cc, 4);
    chk("pre_frz_dst2", dst2cc, 9);

    // freeze for 3 cycles; branch and new instruction ignored
    drive(1, 1, 2, 0, 0, 20, 1, 0, 1, 1);
    chk("frz_flush0", ifid_flush, 0);
    chk("frz_bubble0", idex_bubble, 0);
    for (int i = 0; i < 3; i++) begin
      chk("frz_pchold", pc_hold, 1);
      chk("frz_ifidhold", ifid_hold, 1);
      tick();
      chk("frz_dst1", dst1cc, 4);
      chk("frz_dst2", dst2cc, 9);
      chk("frz_state", state, 2);
    end
    drive(1, 1, 2, 0, 0, 20, 1, 0, 0, 0);
    chk("rel_nohold", pc_hold, 0);
    tick();
    chk("rel_dst1", dst1cc, 20);
    chk("rel_dst2", dst2cc, 4);
    chk("rel_state", state, 0);

    // reset during LDSTALL
    drive(1, 1, 2, 0, 0, 21, 1, 1, 0, 0);
    tick();
    drive(1, 21, 2, 0, 0, 22, 1, 0, 0, 0);
    tick();
    chk("rs_stall_state", state, 1);
`ifdef HAZ_STATS_EN
    chk("st_ldstall", stat_ldstall, 3);
    chk("st_freeze", stat_freeze, 3);
    chk("st_flush", stat_flush, 1);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_state", state, 0);
    chk("rs_dst1", dst1cc, 0);
    chk("rs_dst2", dst2cc, 0);
`ifdef HAZ_STATS_EN
    chk("rs_st_ldstall", stat_ldstall, 0);
    chk("rs_st_freeze", stat_freeze, 0);
    chk("rs_st_flush", stat_flush, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
